pwm_fade_ctrl: RTL

- Bus-configured fade/breathing sequencer that drives the single-LED pwm duty block through that block's existing write interface (sel/wstrb/wdata).
- Ramps the duty from LO to HI and back at a programmable step rate, with optional holds at each end.
- Runs one-shot or looped.
- Sits between the CPU peripheral bus and the pwm instance; the CPU only configures and starts it.

---
 rtl/pwm_fade_pkg.sv | 24 ++
 rtl/pwm_fade_tick.sv | 17 +
 rtl/pwm_fade_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pwm_fade_pkg.sv
// pwm_fade_pkg: shared state encoding, register map and reset defaults for pwm_fade_ctrl.
package pwm_fade_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_HOLD_HI,
    S_DOWN,
    S_HOLD_LO
  } state_e;
  localparam logic [2:0] REG_CTRL = 3'd0;
  localparam logic [2:0] REG_DIV  = 3'd1;
  localparam logic [2:0] REG_LO   = 3'd2;
  localparam logic [2:0] REG_HI   = 3'd3;
  localparam logic [2:0] REG_STEP = 3'd4;
  localparam logic [2:0] REG_HOLD = 3'd5;
  localparam int CTRL_START = 0;
  localparam int CTRL_LOOP  = 1;
  localparam int CTRL_STOP  = 2;
  localparam int DEF_DIV  = 0;
  localparam int DEF_LO   = 0;
  localparam int DEF_STEP = 1;
  localparam int DEF_HOLD = 0;
  localparam logic DEF_LOOP = 1'b0;
endpackage

// File: rtl/pwm_fade_tick.sv
// pwm_fade_tick: step-rate prescaler; tick fires when the count equals div, period div+1.
module pwm_fade_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  assign tick = cnt_q == div;
  always_comb cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: bus-configured LO/HI breathing sequencer writing duty into a pwm block.
// Define PWM_FADE_GAMMA_EN to square-law correct the duty sent to the pwm block.
module pwm_fade_ctrl
  import pwm_fade_pkg::*;
#(
  parameter int WIDTH      = 12,
  parameter int DIV_WIDTH  = 16,
  parameter int HOLD_WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sel,
  input  logic        wstrb,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic        pwm_sel,
  output logic        pwm_wstrb,
  output logic [31:0] pwm_wdata,
  output logic        busy,
  output logic        done
);
  logic [DIV_WIDTH-1:0]  div_q, div_d, s_div_q, s_div_d;
  logic [WIDTH-1:0]      lo_q, lo_d, s_lo_q, s_lo_d;
  logic [WIDTH-1:0]      hi_q, hi_d, s_hi_q, s_hi_d;
  logic [WIDTH-1:0]      step_q, step_d, s_step_q, s_step_d;
  logic [HOLD_WIDTH-1:0] hold_q, hold_d, s_hold_q, s_hold_d;
  logic                  loop_q, loop_d, s_loop_q, s_loop_d;
  state_e                state_q, state_d;
  logic [WIDTH-1:0]      duty_q, duty_d, wdata_q, wdata_d, corr;
  logic [HOLD_WIDTH-1:0] hcnt_q, hcnt_d;
  logic                  strobe_q, strobe_d, done_q, done_d;
  logic                  wr, ctrl_wr, stop, start, tick, hold_last, unused_wdata;
  logic [WIDTH:0]        up_nxt, lo_plus;
  state_e                exit_st;
  assign wr           = sel && wstrb;
  assign ctrl_wr      = wr && addr == REG_CTRL;
  assign stop         = ctrl_wr && wdata[CTRL_STOP];
  assign start        = ctrl_wr && wdata[CTRL_START] && !stop && state_q == S_IDLE;
  assign unused_wdata = ^wdata;
  pwm_fade_tick #(.DIV_WIDTH(DIV_WIDTH)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (start),
    .div  (s_div_q),
    .tick (tick)
  );
  // live config registers; shadows snapshot them at START so a running ramp is unaffected
  always_comb begin
    div_d    = (wr && addr == REG_DIV)  ? wdata[DIV_WIDTH-1:0]  : div_q;
    lo_d     = (wr && addr == REG_LO)   ? wdata[WIDTH-1:0]      : lo_q;
    hi_d     = (wr && addr == REG_HI)   ? wdata[WIDTH-1:0]      : hi_q;
    step_d   = (wr && addr == REG_STEP) ? wdata[WIDTH-1:0]      : step_q;
    hold_d   = (wr && addr == REG_HOLD) ? wdata[HOLD_WIDTH-1:0] : hold_q;
    loop_d   = ctrl_wr ? wdata[CTRL_LOOP] : loop_q;
    s_div_d  = start ? div_d  : s_div_q;
    s_lo_d   = start ? lo_d   : s_lo_q;
    s_hi_d   = start ? hi_d   : s_hi_q;
    s_step_d = start ? ((step_d == '0) ? WIDTH'(1) : step_d) : s_step_q;
    s_hold_d = start ? hold_d : s_hold_q;
    s_loop_d = start ? loop_d : s_loop_q;
  end
  assign up_nxt    = {1'b0, duty_q} + {1'b0, s_step_q};
  assign lo_plus   = {1'b0, s_lo_q} + {1'b0, s_step_q};
  assign hold_last = hcnt_q == s_hold_q - 1'b1;
  assign exit_st   = s_loop_q ? S_UP : S_IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_q    <= DIV_WIDTH'(DEF_DIV);
      lo_q     <= WIDTH'(DEF_LO);
      hi_q     <= '1;
      step_q   <= WIDTH'(DEF_STEP);
      hold_q   <= HOLD_WIDTH'(DEF_HOLD);
      loop_q   <= DEF_LOOP;
      s_div_q  <= DIV_WIDTH'(DEF_DIV);
      s_lo_q   <= WIDTH'(DEF_LO);
      s_hi_q   <= '1;
      s_step_q <= WIDTH'(DEF_STEP);
      s_hold_q <= HOLD_WIDTH'(DEF_HOLD);
      s_loop_q <= DEF_LOOP;
      state_q  <= S_IDLE;
      duty_q   <= '0;
      hcnt_q   <= '0;
      strobe_q <= 1'b0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      step_q   <= step_d;
      hold_q   <= hold_d;
      loop_q   <= loop_d;
      s_div_q  <= s_div_d;
      s_lo_q   <= s_lo_d;
      s_hi_q   <= s_hi_d;
      s_step_q <= s_step_d;
      s_hold_q <= s_hold_d;
      s_loop_q <= s_loop_d;
      state_q  <= state_d;
      duty_q   <= duty_d;
      hcnt_q   <= hcnt_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
    end
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    hcnt_d  = hcnt_q;
    if (stop) begin
      state_d = S_IDLE;
      duty_d  = '0;
    end else if (start) begin
      state_d = (lo_d < hi_d) ? S_UP : S_IDLE;
      duty_d  = lo_d;
      hcnt_d  = '0;
    end else if (tick) begin
      case (state_q)
        S_UP: begin
          duty_d  = (up_nxt >= {1'b0, s_hi_q}) ? s_hi_q : up_nxt[WIDTH-1:0];
          state_d = (up_nxt < {1'b0, s_hi_q}) ? S_UP : (s_hold_q == '0) ? S_DOWN : S_HOLD_HI;
          hcnt_d  = '0;
        end
        S_HOLD_HI: begin
          hcnt_d  = hold_last ? '0 : hcnt_q + 1'b1;
          state_d = hold_last ? S_DOWN : S_HOLD_HI;
        end
        S_DOWN: begin
          duty_d  = ({1'b0, duty_q} <= lo_plus) ? s_lo_q : duty_q - s_step_q;
          state_d = ({1'b0, duty_q} > lo_plus) ? S_DOWN : (s_hold_q == '0) ? exit_st : S_HOLD_LO;
          hcnt_d  = '0;
        end
        S_HOLD_LO: begin
          hcnt_d  = hold_last ? '0 : hcnt_q + 1'b1;
          state_d = hold_last ? exit_st : S_HOLD_LO;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
`ifdef PWM_FADE_GAMMA_EN
  logic [2*WIDTH-1:0] sq;
  assign sq   = {{WIDTH{1'b0}}, duty_d} * {{WIDTH{1'b0}}, duty_d};
  assign corr = sq[2*WIDTH-1:WIDTH];
`else
  assign corr = duty_d;
`endif
  // the strobe carries the duty being entered, so the pwm sees it one cycle after the tick
  always_comb begin
    strobe_d = stop || start || (tick && (state_q == S_UP || state_q == S_DOWN));
    wdata_d  = strobe_d ? corr : wdata_q;
    done_d   = !stop && state_d == S_IDLE && (start || state_q != S_IDLE);
  end
  assign pwm_sel   = strobe_q;
  assign pwm_wstrb = strobe_q;
  assign pwm_wdata = {{(32-WIDTH){1'b0}}, wdata_q};
  assign busy      = state_q != S_IDLE;
  assign done      = done_q;
endmodule
